// File: rtl/countdown_ctrl.sv
// countdown_ctrl: run/pause/reload controller for a 2-digit BCD seconds countdown
// with a multiplexed 2-digit seven-segment display.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-low reset
//   start       pulse: start / resume / restart
//   pause       pulse: pause while running
//   clear       pulse: abort to idle and reload preset
//   load_en     pulse: capture load_bcd as new preset (idle only)
//   load_bcd    {tens,ones} BCD preset value
//   tens, ones  current countdown digits
//   busy        high while running or paused
//   expired     high while the countdown sits at zero
//   done_pulse  one-cycle pulse on reaching zero
//   load_err    one-cycle pulse when a non-BCD load is rejected
//   seg_en      digit enable (01 ones, 10 tens)
//   seg_out     segments {a,b,c,d,e,f,g,dp}, active-high
module countdown_ctrl #(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned SCAN_DIV   = 100_000,
    parameter logic [7:0]  PRESET_BCD = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       load_en,
    input  logic [7:0] load_bcd,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       busy,
    output logic       expired,
    output logic       done_pulse,
    output logic       load_err,
    output logic [1:0] seg_en,
    output logic [7:0] seg_out
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tens_q, tens_d, ones_q, ones_d;
    logic [7:0]    preset_q, preset_d;
    logic          busy_q, busy_d, expired_q, expired_d;
    logic          done_pulse_q, done_pulse_d, load_err_q, load_err_d;
    logic [SW-1:0] scan_q, scan_d;
    logic          phase_q, phase_d;
    logic [1:0]    seg_en_q, seg_en_d;
    logic [7:0]    seg_out_q, seg_out_d;

    logic          tick_c, dec_zero_c, load_ok_c, blank_c, scan_wrap_c;
    logic          cmd_clear_c, cmd_pause_c, cmd_start_c, cmd_load_c;
    logic [3:0]    dec_tens_c, dec_ones_c, digit_c;

    // Seven-segment encoding, {a,b,c,d,e,f,g,dp}; non-decimal shows only dp.
    function automatic logic [7:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 8'hFC;
            4'd1:    enc = 8'h60;
            4'd2:    enc = 8'hDA;
            4'd3:    enc = 8'hF2;
            4'd4:    enc = 8'h66;
            4'd5:    enc = 8'hB6;
            4'd6:    enc = 8'hBE;
            4'd7:    enc = 8'hE0;
            4'd8:    enc = 8'hFE;
            4'd9:    enc = 8'hF6;
            default: enc = 8'h01;
        endcase
    endfunction

    // One command per cycle: clear > pause > start > load_en.
    always_comb begin
        cmd_clear_c = clear;
        cmd_pause_c = !clear && pause;
        cmd_start_c = !clear && !pause && start;
        cmd_load_c  = !clear && !pause && !start && load_en;
    end

    // Countdown FSM next-state and datapath.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        preset_d   = preset_q;
        load_err_d = 1'b0;

        tick_c     = (presc_q == PW'(TICK_DIV - 1));
        load_ok_c  = (load_bcd[7:4] <= 4'd9) && (load_bcd[3:0] <= 4'd9);
        dec_ones_c = (ones_q == 4'd0) ? 4'd9 : ones_q - 4'd1;
        dec_tens_c = (ones_q == 4'd0) ? tens_q - 4'd1 : tens_q;
        dec_zero_c = (tens_q == 4'd0) && (ones_q == 4'd1);

        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                tens_d  = preset_q[7:4];
                ones_d  = preset_q[3:0];
                if (cmd_start_c) begin
                    state_d = (preset_q == 8'h00) ? S_DONE : S_RUN;
                end else if (cmd_load_c) begin
                    if (load_ok_c) begin
                        preset_d = load_bcd;
                        tens_d   = load_bcd[7:4];
                        ones_d   = load_bcd[3:0];
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (cmd_clear_c) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    tens_d  = preset_q[7:4];
                    ones_d  = preset_q[3:0];
                end else if (tick_c) begin
                    // A tick coinciding with pause is still applied before pausing.
                    presc_d = '0;
                    tens_d  = dec_tens_c;
                    ones_d  = dec_ones_c;
                    if (dec_zero_c)       state_d = S_DONE;
                    else if (cmd_pause_c) state_d = S_PAUSE;
                end else if (cmd_pause_c) begin
                    state_d = S_PAUSE;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            S_PAUSE: begin
                if (cmd_clear_c) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    tens_d  = preset_q[7:4];
                    ones_d  = preset_q[3:0];
                end else if (cmd_start_c) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                // Prescaler keeps running here to drive the display blink.
                tens_d  = 4'd0;
                ones_d  = 4'd0;
                presc_d = tick_c ? '0 : presc_q + PW'(1);
                if (cmd_clear_c) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    tens_d  = preset_q[7:4];
                    ones_d  = preset_q[3:0];
                end else if (cmd_start_c) begin
                    presc_d = '0;
                    if (preset_q != 8'h00) begin
                        state_d = S_RUN;
                        tens_d  = preset_q[7:4];
                        ones_d  = preset_q[3:0];
                    end
                end
            end
        endcase

        busy_d       = (state_d == S_RUN) || (state_d == S_PAUSE);
        expired_d    = (state_d == S_DONE);
        done_pulse_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    // Digit scan: alternate digits on each scan-counter wrap.
    always_comb begin
        scan_wrap_c = (scan_q == SW'(SCAN_DIV - 1));
        blank_c     = (state_q == S_DONE) && (presc_q >= PW'(TICK_DIV / 2));
        scan_d      = scan_wrap_c ? '0 : scan_q + SW'(1);
        phase_d     = phase_q;
        seg_en_d    = seg_en_q;
        seg_out_d   = seg_out_q;
        digit_c     = ones_q;
        if (scan_wrap_c) begin
            phase_d   = !phase_q;
            digit_c   = phase_d ? tens_q : ones_q;
            seg_en_d  = phase_d ? 2'b10 : 2'b01;
            seg_out_d = blank_c ? 8'h00 : enc(digit_c);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            tens_q       <= PRESET_BCD[7:4];
            ones_q       <= PRESET_BCD[3:0];
            preset_q     <= PRESET_BCD;
            busy_q       <= 1'b0;
            expired_q    <= 1'b0;
            done_pulse_q <= 1'b0;
            load_err_q   <= 1'b0;
            scan_q       <= '0;
            phase_q      <= 1'b1;   // so the first scan phase shows the ones digit
            seg_en_q     <= 2'b00;
            seg_out_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            preset_q     <= preset_d;
            busy_q       <= busy_d;
            expired_q    <= expired_d;
            done_pulse_q <= done_pulse_d;
            load_err_q   <= load_err_d;
            scan_q       <= scan_d;
            phase_q      <= phase_d;
            seg_en_q     <= seg_en_d;
            seg_out_q    <= seg_out_d;
        end
    end

    assign tens       = tens_q;
    assign ones       = ones_q;
    assign busy       = busy_q;
    assign expired    = expired_q;
    assign done_pulse = done_pulse_q;
    assign load_err   = load_err_q;
    assign seg_en     = seg_en_q;
    assign seg_out    = seg_out_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed testbench for countdown_ctrl with TICK_DIV=4, SCAN_DIV=2.
module tb_countdown_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, pause, clear, load_en;
    logic [7:0] load_bcd;
    logic [3:0] tens, ones;
    logic       busy, expired, done_pulse, load_err;
    logic [1:0] seg_en;
    logic [7:0] seg_out;

    int n_cmp = 0;
    int n_err = 0;

    countdown_ctrl #(
        .TICK_DIV  (4),
        .SCAN_DIV  (2),
        .PRESET_BCD(8'h59)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .clear     (clear),
        .load_en   (load_en),
        .load_bcd  (load_bcd),
        .tens      (tens),
        .ones      (ones),
        .busy      (busy),
        .expired   (expired),
        .done_pulse(done_pulse),
        .load_err  (load_err),
        .seg_en    (seg_en),
        .seg_out   (seg_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold the given commands for exactly one rising edge.
    task automatic cmd(input logic s, input logic p, input logic c, input logic l,
                       input logic [7:0] bcd);
        start = s; pause = p; clear = c; load_en = l; load_bcd = bcd;
        step(1);
        start = 1'b0; pause = 1'b0; clear = 1'b0; load_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; load_en = 1'b0; load_bcd = 8'h00;
        #1 rst = 1'b0;
        #2;
        // Reset values
        chk("rst_digits", {tens, ones}, 8'h59);
        chk("rst_busy", busy, 1'b0);
        chk("rst_expired", expired, 1'b0);
        chk("rst_done_pulse", done_pulse, 1'b0);
        chk("rst_load_err", load_err, 1'b0);
        chk("rst_seg_en", seg_en, 2'b00);
        chk("rst_seg_out", seg_out, 8'h00);
        @(posedge clk); #1 rst = 1'b1;

        // 1: load 12, run to zero
        cmd(0, 0, 0, 1, 8'h12);
        chk("t1_load", {tens, ones}, 8'h12);
        chk("t1_load_err", load_err, 1'b0);
        cmd(1, 0, 0, 0, 8'h00);
        chk("t1_busy", busy, 1'b1);
        step(3);
        chk("t1_pre_tick", {tens, ones}, 8'h12);
        step(1);
        chk("t1_first_tick", {tens, ones}, 8'h11);
        step(43);
        chk("t1_at_01", {tens, ones}, 8'h01);
        chk("t1_not_expired", expired, 1'b0);
        step(1);
        chk("t1_zero", {tens, ones}, 8'h00);
        chk("t1_expired", expired, 1'b1);
        chk("t1_done_pulse", done_pulse, 1'b1);
        chk("t1_busy_done", busy, 1'b0);
        step(1);
        chk("t1_done_pulse_gone", done_pulse, 1'b0);
        chk("t1_expired_hold", expired, 1'b1);
        chk("t1_zero_hold", {tens, ones}, 8'h00);

        // 2: tens borrow, and 01 expiring on first tick
        cmd(0, 0, 1, 0, 8'h00);
        chk("t2_clear_reload", {tens, ones}, 8'h12);
        chk("t2_clear_expired", expired, 1'b0);
        cmd(0, 0, 0, 1, 8'h20);
        cmd(1, 0, 0, 0, 8'h00);
        step(4);
        chk("t2_borrow", {tens, ones}, 8'h19);
        cmd(0, 0, 1, 0, 8'h00);
        cmd(0, 0, 0, 1, 8'h01);
        cmd(1, 0, 0, 0, 8'h00);
        step(3);
        chk("t2_01_hold", {tens, ones}, 8'h01);
        step(1);
        chk("t2_01_done", {tens, ones}, 8'h00);
        chk("t2_01_expired", expired, 1'b1);
        chk("t2_01_pulse", done_pulse, 1'b1);

        // 3: pause with prescaler at 2, resume keeps the partial second
        cmd(0, 0, 1, 0, 8'h00);
        cmd(0, 0, 0, 1, 8'h05);
        cmd(1, 0, 0, 0, 8'h00);
        step(2);
        cmd(0, 1, 0, 0, 8'h00);
        chk("t3_paused_busy", busy, 1'b1);
        step(10);
        chk("t3_paused_digits", {tens, ones}, 8'h05);
        chk("t3_paused_busy2", busy, 1'b1);
        cmd(1, 0, 0, 0, 8'h00);
        step(1);
        chk("t3_resume_hold", {tens, ones}, 8'h05);
        step(1);
        chk("t3_resume_tick", {tens, ones}, 8'h04);

        // 4: rejected loads and zero preset
        cmd(0, 0, 1, 0, 8'h00);
        chk("t4_clear", {tens, ones}, 8'h05);
        cmd(0, 0, 0, 1, 8'h1A);
        chk("t4_bad_load_err", load_err, 1'b1);
        chk("t4_bad_load_digits", {tens, ones}, 8'h05);
        step(1);
        chk("t4_load_err_pulse", load_err, 1'b0);
        cmd(1, 0, 0, 0, 8'h00);
        cmd(0, 0, 0, 1, 8'h33);
        chk("t4_run_load_err", load_err, 1'b0);
        chk("t4_run_load_digits", {tens, ones}, 8'h05);
        cmd(0, 0, 1, 0, 8'h00);
        chk("t4_preset_kept", {tens, ones}, 8'h05);
        cmd(0, 0, 0, 1, 8'h00);
        cmd(1, 0, 0, 0, 8'h00);
        chk("t4_zero_expired", expired, 1'b1);
        chk("t4_zero_pulse", done_pulse, 1'b1);
        chk("t4_zero_busy", busy, 1'b0);

        // 5: command priority, then reset mid-run
        cmd(0, 0, 1, 0, 8'h00);
        cmd(0, 0, 0, 1, 8'h42);
        cmd(1, 0, 0, 0, 8'h00);
        step(2);
        cmd(1, 1, 1, 0, 8'h00);
        chk("t5_prio_busy", busy, 1'b0);
        chk("t5_prio_digits", {tens, ones}, 8'h42);
        cmd(1, 0, 0, 0, 8'h00);
        step(5);
        chk("t5_running", {tens, ones}, 8'h41);
        rst = 1'b0;
        #1;
        chk("t5_rst_digits", {tens, ones}, 8'h59);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_seg_en", seg_en, 2'b00);
        chk("t5_rst_seg_out", seg_out, 8'h00);
        @(posedge clk); #1 rst = 1'b1;
        chk("t5_preset_restored", {tens, ones}, 8'h59);

        // 6: scan of 37, then blink in DONE
        cmd(0, 0, 0, 1, 8'h37);
        step(1);
        chk("t6_scan_en_a", seg_en, 2'b01);
        chk("t6_scan_out_a", seg_out, 8'hE0);
        step(1);
        chk("t6_scan_en_hold", seg_en, 2'b01);
        step(1);
        chk("t6_scan_en_b", seg_en, 2'b10);
        chk("t6_scan_out_b", seg_out, 8'hF2);
        step(2);
        chk("t6_scan_en_c", seg_en, 2'b01);
        chk("t6_scan_out_c", seg_out, 8'hE0);
        cmd(0, 0, 0, 1, 8'h00);
        cmd(1, 0, 0, 0, 8'h00);
        chk("t6_done_entry", expired, 1'b1);
        chk("t6_blink_a", {6'd0, seg_en, seg_out}, {6'd0, 2'b10, 8'hFC});
        step(2);
        chk("t6_blink_b", {6'd0, seg_en, seg_out}, {6'd0, 2'b01, 8'hFC});
        step(2);
        chk("t6_blink_c", {6'd0, seg_en, seg_out}, {6'd0, 2'b10, 8'h00});
        step(2);
        chk("t6_blink_d", {6'd0, seg_en, seg_out}, {6'd0, 2'b01, 8'hFC});
        step(2);
        chk("t6_blink_e", {6'd0, seg_en, seg_out}, {6'd0, 2'b10, 8'h00});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
